rx_state_update: RTL and testbench

Receive-pipeline client of the receive state store. Takes one parsed data segment at a time, reads the flow's `recv_state_entry` over the store's current-state read port, and checks the segment's sequence number against the stored `ack_num`. On an in-order match it advances `ack_num` by the payload length and writes the entry back over the store's write port. It then reports accept/reject and the resulting ack number downstream to the ACK/send-pipe notifier.

---
 rtl/rx_state_update.sv | 117 +++++++++++
 tb/tb_rx_state_update.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_state_update.sv
// Receive-state updater: reads a flow's entry, checks the segment sequence against ack_num,
// writes back the advanced ack_num on an in-order hit and reports accept/ack downstream.
package tcp_pkg;
   localparam int FLOWID_W           = 8;
   localparam int RECV_STATE_ENTRY_W = 64;
   localparam int ACK_NUM_LSB        = 0;
endpackage

module rx_state_update #(
   parameter int FLOWID_W           = tcp_pkg::FLOWID_W,
   parameter int RECV_STATE_ENTRY_W = tcp_pkg::RECV_STATE_ENTRY_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          seg_val,
   input  logic [FLOWID_W-1:0]           seg_flowid,
   input  logic [31:0]                   seg_seq_num,
   input  logic [15:0]                   seg_payload_len,
   output logic                          seg_rdy,
   output logic                          curr_recv_state_rd_req_val,
   output logic [FLOWID_W-1:0]           curr_recv_state_rd_req_addr,
   input  logic                          curr_recv_state_rd_req_rdy,
   input  logic                          curr_recv_state_rd_resp_val,
   input  logic [RECV_STATE_ENTRY_W-1:0] curr_recv_state_rd_resp_data,
   output logic                          curr_recv_state_rd_resp_rdy,
   output logic                          recv_state_wr_req_val,
   output logic [FLOWID_W-1:0]           recv_state_wr_req_addr,
   output logic [RECV_STATE_ENTRY_W-1:0] recv_state_wr_req_data,
   input  logic                          recv_state_wr_req_rdy,
   output logic                          result_val,
   output logic [FLOWID_W-1:0]           result_flowid,
   output logic                          result_accept,
   output logic [31:0]                   result_ack_num,
   input  logic                          result_rdy
);

   localparam int ACK_LSB = tcp_pkg::ACK_NUM_LSB;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, OUT} state_e;

   state_e                        state_q, state_d;
   logic [FLOWID_W-1:0]           flowid_q, flowid_d;
   logic [31:0]                   seq_q, seq_d;
   logic [15:0]                   len_q, len_d;
   logic [RECV_STATE_ENTRY_W-1:0] entry_q, entry_d;
   logic                          accept_q, accept_d;
   logic                          resp_accept;

   assign resp_accept = (seq_q == curr_recv_state_rd_resp_data[ACK_LSB +: 32]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         flowid_q <= '0;
         seq_q    <= '0;
         len_q    <= '0;
         entry_q  <= '0;
         accept_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         flowid_q <= flowid_d;
         seq_q    <= seq_d;
         len_q    <= len_d;
         entry_q  <= entry_d;
         accept_q <= accept_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (seg_val)                     state_d = RD_REQ;
         RD_REQ:  if (curr_recv_state_rd_req_rdy)  state_d = RD_WAIT;
         RD_WAIT: if (curr_recv_state_rd_resp_val)
                     state_d = (resp_accept && len_q != 16'd0) ? WR : OUT;
         WR:      if (recv_state_wr_req_rdy)       state_d = OUT;
         OUT:     if (result_rdy)                  state_d = IDLE;
         default:                                  state_d = IDLE;
      endcase
   end

   // Segment fields latch on the IDLE handshake; the entry latches on the read response.
   always_comb begin
      flowid_d = flowid_q;
      seq_d    = seq_q;
      len_d    = len_q;
      entry_d  = entry_q;
      accept_d = accept_q;
      if (state_q == IDLE && seg_val) begin
         flowid_d = seg_flowid;
         seq_d    = seg_seq_num;
         len_d    = seg_payload_len;
      end
      if (state_q == RD_WAIT && curr_recv_state_rd_resp_val) begin
         accept_d = resp_accept;
         entry_d  = curr_recv_state_rd_resp_data;
         if (resp_accept)
            entry_d[ACK_LSB +: 32] = curr_recv_state_rd_resp_data[ACK_LSB +: 32] + {16'd0, len_q};
      end
   end

   always_comb begin
      seg_rdy                     = (state_q == IDLE) && !rst;
      curr_recv_state_rd_req_val  = (state_q == RD_REQ);
      curr_recv_state_rd_resp_rdy = (state_q == RD_WAIT);
      recv_state_wr_req_val       = (state_q == WR);
      result_val                  = (state_q == OUT);
   end

   assign curr_recv_state_rd_req_addr = flowid_q;
   assign recv_state_wr_req_addr      = flowid_q;
   assign recv_state_wr_req_data      = entry_q;
   assign result_flowid               = flowid_q;
   assign result_accept               = accept_q;
   assign result_ack_num              = entry_q[ACK_LSB +: 32];

endmodule

// File: tb/tb_rx_state_update.sv
// Bench for rx_state_update: store/notifier models driven at negedge, outcomes predicted
// from a flow table updated with plain arithmetic.
module tb_rx_state_update;
   import tcp_pkg::*;
   localparam int FW = FLOWID_W;
   localparam int EW = RECV_STATE_ENTRY_W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          seg_val = 1'b0;
   logic [FW-1:0] seg_flowid = '0;
   logic [31:0]   seg_seq_num = '0;
   logic [15:0]   seg_payload_len = '0;
   logic          seg_rdy;
   logic          rd_req_val;
   logic [FW-1:0] rd_req_addr;
   logic          rd_req_rdy = 1'b1;
   logic          rd_resp_val = 1'b0;
   logic [EW-1:0] rd_resp_data = '0;
   logic          rd_resp_rdy;
   logic          wr_req_val;
   logic [FW-1:0] wr_req_addr;
   logic [EW-1:0] wr_req_data;
   logic          wr_req_rdy = 1'b1;
   logic          result_val;
   logic [FW-1:0] result_flowid;
   logic          result_accept;
   logic [31:0]   result_ack_num;
   logic          result_rdy = 1'b1;

   always #5 clk = ~clk;

   rx_state_update dut (
      .clk(clk), .rst(rst),
      .seg_val(seg_val), .seg_flowid(seg_flowid), .seg_seq_num(seg_seq_num),
      .seg_payload_len(seg_payload_len), .seg_rdy(seg_rdy),
      .curr_recv_state_rd_req_val(rd_req_val), .curr_recv_state_rd_req_addr(rd_req_addr),
      .curr_recv_state_rd_req_rdy(rd_req_rdy), .curr_recv_state_rd_resp_val(rd_resp_val),
      .curr_recv_state_rd_resp_data(rd_resp_data), .curr_recv_state_rd_resp_rdy(rd_resp_rdy),
      .recv_state_wr_req_val(wr_req_val), .recv_state_wr_req_addr(wr_req_addr),
      .recv_state_wr_req_data(wr_req_data), .recv_state_wr_req_rdy(wr_req_rdy),
      .result_val(result_val), .result_flowid(result_flowid), .result_accept(result_accept),
      .result_ack_num(result_ack_num), .result_rdy(result_rdy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   logic [EW-1:0] store_mem [256];
   logic [EW-1:0] ref_mem   [256];

   int            cyc = 0;
   bit            seg_req = 0;
   logic [FW-1:0] s_flow;
   logic [31:0]   s_seq;
   logic [15:0]   s_len;
   bit            pend = 0, resp_hold = 0, resp_hs = 0;
   logic [FW-1:0] pend_addr;
   bit            rd_rand = 0, wr_rand = 0, res_rand = 0, wr_en = 1, res_en = 1;
   int            wr_cnt = 0, res_cnt = 0, seg_cyc = 0, res_cyc = 0;
   logic [FW-1:0] last_wr_addr, r_flow;
   logic [EW-1:0] last_wr_data, last_resp_data;
   logic          r_acc;
   logic [31:0]   r_ack;
   bit            p_rst = 1;
   bit            p_rd_val = 0, p_rd_hs = 0, p_wr_val = 0, p_wr_hs = 0, p_res_val = 0, p_res_hs = 0;
   logic [FW-1:0] p_rd_addr, p_wr_addr;
   logic [EW-1:0] p_wr_data;
   logic [31:0]   p_res_ack;
   logic          p_res_acc;

   // Expected outcome of the segment currently in flight.
   bit            exp_acc, exp_wr;
   logic [31:0]   exp_ack;
   logic [FW-1:0] exp_flow;
   logic [EW-1:0] exp_entry;
   int            w0, r0;

   task automatic cycle();
      @(negedge clk);
      cyc++;
      if (rst) begin
         pend = 0; rd_resp_val = 0; resp_hs = 0; seg_req = 0; seg_val = 0;
         p_rst = 1; p_rd_val = 0; p_wr_val = 0; p_res_val = 0;
         return;
      end
      if (!p_rst) begin
         if (p_rd_val && !p_rd_hs) begin
            check("rd_val_hold", rd_req_val, 1);
            check("rd_addr_hold", rd_req_addr, p_rd_addr);
         end
         if (p_wr_val && !p_wr_hs) begin
            check("wr_val_hold", wr_req_val, 1);
            check("wr_addr_hold", wr_req_addr, p_wr_addr);
            check("wr_data_hold", wr_req_data, p_wr_data);
         end
         if (p_res_val && !p_res_hs) begin
            check("res_val_hold", result_val, 1);
            check("res_hold", {result_accept, result_ack_num}, {p_res_acc, p_res_ack});
         end
      end
      p_rst = 0;
      seg_val = seg_req; seg_flowid = s_flow; seg_seq_num = s_seq; seg_payload_len = s_len;
      if (resp_hs) rd_resp_val = 0;
      if (pend && !resp_hold) begin
         rd_resp_val = 1; rd_resp_data = store_mem[pend_addr];
         last_resp_data = store_mem[pend_addr]; pend = 0;
      end
      rd_req_rdy = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_req_rdy = wr_en && (wr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      result_rdy = res_en && (res_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (seg_val && seg_rdy) begin seg_req = 0; seg_cyc = cyc; end
      if (rd_req_val && rd_req_rdy) begin pend = 1; pend_addr = rd_req_addr; end
      resp_hs = rd_resp_val && rd_resp_rdy;
      if (wr_req_val && wr_req_rdy) begin
         store_mem[wr_req_addr] = wr_req_data; wr_cnt++;
         last_wr_addr = wr_req_addr; last_wr_data = wr_req_data;
      end
      if (result_val && result_rdy) begin
         res_cnt++; res_cyc = cyc;
         r_flow = result_flowid; r_acc = result_accept; r_ack = result_ack_num;
      end
      p_rd_val = rd_req_val; p_rd_hs = rd_req_val && rd_req_rdy; p_rd_addr = rd_req_addr;
      p_wr_val = wr_req_val; p_wr_hs = wr_req_val && wr_req_rdy;
      p_wr_addr = wr_req_addr; p_wr_data = wr_req_data;
      p_res_val = result_val; p_res_hs = result_val && result_rdy;
      p_res_acc = result_accept; p_res_ack = result_ack_num;
   endtask

   task automatic start_seg(input logic [FW-1:0] f, input logic [31:0] seq, input logic [15:0] len);
      logic [31:0] ack;
      ack       = ref_mem[f][31:0];
      exp_flow  = f;
      exp_acc   = (seq == ack);
      exp_wr    = exp_acc && (len != 0);
      exp_ack   = exp_wr ? 32'((longint'(ack) + longint'(len)) % 64'd4294967296) : ack;
      exp_entry = ref_mem[f];
      exp_entry[31:0] = exp_ack;
      ref_mem[f] = exp_entry;
      w0 = wr_cnt; r0 = res_cnt;
      s_flow = f; s_seq = seq; s_len = len; seg_req = 1;
   endtask

   task automatic finish_seg(input string tag, input int exp_lat);
      for (int i = 0; i < 400 && res_cnt == r0; i++) cycle();
      check({tag, "_result_count"}, res_cnt, r0 + 1);
      check({tag, "_accept"}, r_acc, exp_acc);
      check({tag, "_ack"}, r_ack, exp_ack);
      check({tag, "_flow"}, r_flow, exp_flow);
      check({tag, "_writes"}, wr_cnt - w0, exp_wr ? 1 : 0);
      if (exp_wr) begin
         check({tag, "_wr_addr"}, last_wr_addr, exp_flow);
         check({tag, "_wr_data"}, last_wr_data, exp_entry);
      end
      if (exp_lat > 0) check({tag, "_latency"}, res_cyc - seg_cyc, exp_lat);
   endtask

   task automatic set_ack(input int f, input logic [31:0] ack);
      logic [EW-1:0] v;
      v = {$urandom, $urandom};
      v[31:0] = ack;
      store_mem[f] = v; ref_mem[f] = v;
   endtask

   initial begin
      logic [FW-1:0] f;
      logic [31:0]   sq;
      logic [15:0]   ln;
      int            bad;
      for (int i = 0; i < 256; i++) begin
         store_mem[i] = {$urandom, $urandom};
         ref_mem[i]   = store_mem[i];
      end

      cycle(); cycle();
      check("rst_seg_rdy", seg_rdy, 0);
      check("rst_vals", {rd_req_val, rd_resp_rdy, wr_req_val, result_val}, 0);
      check("rst_data", {rd_req_addr, wr_req_addr, result_flowid, result_accept, result_ack_num}, 0);
      check("rst_wr_data", wr_req_data, 0);
      rst = 0;
      #1;
      check("post_rst_seg_rdy", seg_rdy, 1);
      cycle();

      set_ack(3, 1000);
      start_seg(3, 1000, 200); finish_seg("inorder", 4);
      set_ack(3, 1000);
      start_seg(3, 900, 50);   finish_seg("reject", 3);
      set_ack(7, 32'hFFFF_FF00);
      start_seg(7, 32'hFFFF_FF00, 16'h180); finish_seg("wrap", 4);
      check("wrap_value", r_ack, 32'h0000_0080);

      set_ack(5, 0);
      start_seg(5, 0, 100);   finish_seg("b2b_1", 4);
      start_seg(5, 100, 50);  finish_seg("b2b_2", 4);
      check("b2b_read", last_resp_data[31:0], 100);
      check("b2b_final", r_ack, 150);

      // Back-pressure on the write port and on the result port.
      wr_en = 0; res_en = 0;
      start_seg(5, 150, 10);
      for (int i = 0; i < 40 && !wr_req_val; i++) cycle();
      check("stall_wr_seen", wr_req_val, 1);
      for (int i = 0; i < 6; i++) begin
         cycle();
         check("stall_wr_seg_rdy", seg_rdy, 0);
      end
      wr_en = 1;
      for (int i = 0; i < 40 && !result_val; i++) cycle();
      check("stall_res_seen", result_val, 1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("stall_res_seg_rdy", seg_rdy, 0);
      end
      res_en = 1;
      finish_seg("stall", 0);
      for (int i = 0; i < 3; i++) cycle();
      check("stall_single_write", wr_cnt - w0, 1);
      check("stall_single_result", res_cnt - r0, 1);

      // Reset while waiting for the read response.
      resp_hold = 1; w0 = wr_cnt; r0 = res_cnt;
      set_ack(9, 500);
      s_flow = 9; s_seq = 500; s_len = 20; seg_req = 1;
      for (int i = 0; i < 40 && !rd_resp_rdy; i++) cycle();
      check("rstmid_in_rd_wait", rd_resp_rdy, 1);
      rst = 1;
      cycle();
      rst = 0; resp_hold = 0;
      #1;
      check("rstmid_seg_rdy", seg_rdy, 1);
      check("rstmid_idle", {rd_req_val, rd_resp_rdy, wr_req_val, result_val}, 0);
      for (int i = 0; i < 4; i++) cycle();
      check("rstmid_no_write", wr_cnt - w0, 0);
      check("rstmid_no_result", res_cnt - r0, 0);
      start_seg(9, 500, 20); finish_seg("after_rst", 4);

      set_ack(2, 7777);
      start_seg(2, 7777, 0); finish_seg("len0", 3);

      rd_rand = 1; wr_rand = 1; res_rand = 1;
      for (int n = 0; n < 60; n++) begin
         f  = FW'($urandom_range(0, 7));
         sq = ($urandom_range(0, 3) != 0) ? ref_mem[f][31:0] : $urandom;
         ln = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
         if ($urandom_range(0, 9) == 0) set_ack(f, 32'hFFFF_FFFF - $urandom_range(0, 100));
         if ($urandom_range(0, 9) == 0) sq = ref_mem[f][31:0];
         start_seg(f, sq, ln);
         finish_seg("rand", 0);
      end

      bad = 0;
      for (int i = 0; i < 256; i++) if (store_mem[i] !== ref_mem[i]) bad++;
      check("final_store_image", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
